// File: rtl/div_unit_if.sv
// div_unit_if: issue/result bundle between a pipeline stage and div_unit.
// The master side issues operands; the slave side returns the result.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic               annul_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;

    modport master (
        output start_i,
        output annul_i,
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        input  result_o,
        input  ready_o,
        input  busy_o
    );

    modport slave (
        input  start_i,
        input  annul_i,
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        output result_o,
        output ready_o,
        output busy_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider returning {remainder, quotient}.
// Signed division is built only when DIV_SIGNED_EN is defined.
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        FREE,
        BY_ZERO,
        ON,
        END
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               rdy_q, rdy_d;

    logic               accept;
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [WIDTH-1:0]   sub;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   q_fin, r_fin;

    assign accept = bus.start_i & ~bus.annul_i;

    // quo_q starts as the dividend and is shifted out MSB-first
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, dvsr_q};
    assign sub    = rem_sh[WIDTH-1:0] - dvsr_q;

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic a_neg, b_neg;

    assign a_neg = bus.signed_div_i
                 & bus.opdata1_i[WIDTH-1];
    assign b_neg = bus.signed_div_i
                 & bus.opdata2_i[WIDTH-1];
    assign a_mag = a_neg ? -bus.opdata1_i
                         : bus.opdata1_i;
    assign b_mag = b_neg ? -bus.opdata2_i
                         : bus.opdata2_i;
    assign q_fin = qneg_q ? -quo_q : quo_q;
    assign r_fin = rneg_q ? -rem_q : rem_q;

    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (state_q == FREE && accept) begin
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = bus.signed_div_i;
    assign a_mag = bus.opdata1_i;
    assign b_mag = bus.opdata2_i;
    assign q_fin = quo_q;
    assign r_fin = rem_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FREE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            res_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            res_q   <= res_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FREE: begin
                if (accept) begin
                    state_d = (bus.opdata2_i == '0)
                            ? BY_ZERO : ON;
                end
            end
            BY_ZERO: begin
                state_d = bus.annul_i ? FREE : END;
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d = FREE;
                end else if (cnt_q == LAST) begin
                    state_d = END;
                end
            end
            END: begin
                if (!bus.start_i) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        res_d  = res_q;
        rdy_d  = 1'b0;
        unique case (state_q)
            FREE: begin
                if (accept) begin
                    quo_d  = a_mag;
                    dvsr_d = b_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                end
            end
            BY_ZERO: begin
                res_d = '0;
                rdy_d = ~bus.annul_i;
            end
            ON: begin
                if (bus.annul_i) begin
                    res_d = '0;
                end else if (cnt_q == LAST) begin
                    res_d = {r_fin, q_fin};
                    rdy_d = 1'b1;
                end else begin
                    rem_d = ge ? sub : rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ge};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            END: begin
                rdy_d = bus.start_i;
                if (!bus.start_i) begin
                    res_d = '0;
                end
            end
            default: begin
                res_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.busy_o   = (state_q == BY_ZERO)
                     | (state_q == ON);
        bus.ready_o  = rdy_q;
        bus.result_o = res_q;
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: vector table plus scoreboard for div_unit,
// with hand-written annul and mid-operation reset sequences.
module tb_div_unit;
    localparam int W = 32;
    localparam int LNZ = W + 1;
`ifdef DIV_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    typedef struct {
        logic          sgn;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        int            lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [2*W-1:0] sbq[$];
    vec_t tbl[11];

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(
        input logic sgn,
        input logic [W-1:0] a,
        input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) return '0;
        if (sgn && SEN) begin
            if (a == 32'h8000_0000 && b == '1)
                return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    task automatic issue(input string nm,
                         input logic sgn,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [2*W-1:0] exp,
                         input int lat);
        int edges;
        int busy_n;
        logic [2*W-1:0] got;
        logic [2*W-1:0] want;
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        sbq.push_back(exp);
        @(posedge clk);
        #1;
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
        bus.signed_div_i = ~sgn;
        edges  = 0;
        busy_n = int'(bus.busy_o);
        while (!bus.ready_o && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            busy_n += int'(bus.busy_o);
        end
        chk({nm, " latency"}, 64'(edges), 64'(lat));
        chk({nm, " busy cycles"}, 64'(busy_n), 64'(lat));
        if (bus.ready_o) begin
            got = bus.result_o;
            if (sbq.size() == 0) begin
                chk({nm, " scoreboard empty"}, 64'(1), 64'(0));
            end else begin
                want = sbq.pop_front();
                chk({nm, " result"}, got, want);
            end
            repeat (2) @(posedge clk);
            #1;
            chk({nm, " hold"},
                {bus.result_o[62:0], bus.ready_o},
                {got[62:0], 1'b1});
        end else begin
            void'(sbq.pop_front());
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " release"},
            {bus.result_o[61:0], bus.ready_o, bus.busy_o},
            64'(0));
    endtask

    initial begin
        logic s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int rdy_seen;

        tbl[0]  = '{1'b0, 100, 7, 32'hE, 32'h2, LNZ};
        tbl[1]  = '{1'b0, 32'h1234, 0, 0, 0, 1};
        tbl[2]  = '{1'b1, -32'sd7, 2,
                    SEN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
                    SEN ? 32'hFFFF_FFFF : 32'h1, LNZ};
        tbl[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                    SEN ? 32'h8000_0000 : 32'h0,
                    SEN ? 32'h0 : 32'h8000_0000, LNZ};
        tbl[4]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h0, 32'h8000_0000, LNZ};
        tbl[5]  = '{1'b0, 32'hFFFF_FFFF, 1,
                    32'hFFFF_FFFF, 0, LNZ};
        tbl[6]  = '{1'b0, 5, 9, 0, 5, LNZ};
        tbl[7]  = '{1'b1, 7, -32'sd2,
                    SEN ? 32'hFFFF_FFFD : 32'h0,
                    SEN ? 32'h1 : 32'h7, LNZ};
        tbl[8]  = '{1'b1, -32'sd8, -32'sd3,
                    SEN ? 32'h2 : 32'h0,
                    SEN ? 32'hFFFF_FFFE : 32'hFFFF_FFF8, LNZ};
        tbl[9]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    1, 0, LNZ};
        tbl[10] = '{1'b1, 0, 0, 0, 0, 1};

        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;

        repeat (2) @(negedge clk);
        chk("reset outputs",
            {bus.result_o[61:0], bus.ready_o, bus.busy_o},
            64'(0));
        rst = 1'b1;

        foreach (tbl[i]) begin
            issue($sformatf("vec%0d", i), tbl[i].sgn,
                  tbl[i].a, tbl[i].b,
                  {tbl[i].r, tbl[i].q}, tbl[i].lat);
        end

        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 20))
                             : W'($urandom);
            issue($sformatf("rnd%0d", i), s, a, b,
                  model(s, a, b), (b == '0) ? 1 : LNZ);
        end

        // annul at step 10 of 100 / 7
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 100;
        bus.opdata2_i    = 7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("annul pre busy", 64'(bus.busy_o), 64'(1));
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("annul free",
            {bus.result_o[61:0], bus.ready_o, bus.busy_o},
            64'(0));
        @(negedge clk);
        bus.annul_i = 1'b0;
        rdy_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            rdy_seen += int'(bus.ready_o);
        end
        chk("annul no ready", 64'(rdy_seen), 64'(0));
        issue("after annul 9/3", 1'b0, 9, 3,
              {32'h0, 32'h3}, LNZ);

        // asynchronous reset at step 5
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.opdata1_i = 100;
        bus.opdata2_i = 7;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset",
            {bus.result_o[61:0], bus.ready_o, bus.busy_o},
            64'(0));
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue("after reset 100/7", 1'b0, 100, 7,
              {32'h2, 32'hE}, LNZ);

        chk("scoreboard drained", 64'(sbq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
